// File: rtl/tl_xbar_pkg.sv
// Types and constants shared by the crossbar arbitration blocks.
package tl_xbar_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tl_skid_buffer.sv
// Two-entry skid buffer: registered outputs, full throughput, in_ready_o from state only.
module tl_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             r_main_valid;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_load_main;

  assign w_load_main = !r_main_valid || out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_data  <= '0;
    end else if (w_load_main) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= in_valid_i;
        if (in_valid_i) begin
          r_main_data <= in_data_i;
        end
      end
    end else if (in_valid_i && !r_skid_valid) begin
      // Output stalled: park the accepted beat so upstream never sees ready drop late.
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data_i;
    end
  end

  assign in_ready_o  = !r_skid_valid;
  assign out_valid_o = r_main_valid;
  assign out_data_o  = r_main_data;

endmodule

// File: rtl/tl_burst_arbiter.sv
// N-channel burst arbiter: round-robin or fixed priority, grant held for multi-beat bursts,
// optional registered output stage.
module tl_burst_arbiter
  import tl_xbar_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OUT_REG = 0,
  localparam int unsigned IDX_W  = idx_width(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        valid_i,
  output logic [N-1:0]        ready_o,
  input  logic [N*DATA_W-1:0] data_i,
  input  logic [N-1:0]        last_i,
  input  logic                prio_mode_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                last_o,
  output logic [IDX_W-1:0]    id_o,
  output logic                locked_o
);

  localparam int unsigned PW = DATA_W + IDX_W + 1;

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  w_rr_next;
  logic [IDX_W-1:0]  r_lock_idx;
  logic [IDX_W-1:0]  w_lock_next;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic [IDX_W-1:0]  w_cand;
  logic              w_gnt_valid;
  logic              w_gnt_last;
  logic              w_dn_ready;
  logic              w_xfer;
  logic [DATA_W-1:0] w_data_arr [N];
  logic [DATA_W-1:0] w_gnt_data;
  logic [N-1:0]      w_ready;
  logic              w_out_valid;
  logic [PW-1:0]     w_in_payload;
  logic [PW-1:0]     w_out_payload;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign w_data_arr[k] = data_i[k*DATA_W +: DATA_W];
  end

  // Winner select: the locked channel only, otherwise a scan from rr_ptr (or from 0).
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    if (r_state == ARB_LOCKED) begin
      w_gnt_idx   = r_lock_idx;
      w_gnt_valid = valid_i[r_lock_idx];
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (prio_mode_i == MODE_FIXED) begin
          w_cand = IDX_W'(i);
        end else begin
          w_cand = IDX_W'((32'(r_rr_ptr) + i) % N);
        end
        if (!w_gnt_valid && valid_i[w_cand]) begin
          w_gnt_valid = 1'b1;
          w_gnt_idx   = w_cand;
        end
      end
    end
  end

  assign w_gnt_last = last_i[w_gnt_idx];
  assign w_gnt_data = w_data_arr[w_gnt_idx];
  assign w_xfer     = w_gnt_valid && w_dn_ready;

  always_comb begin
    w_state_next = r_state;
    w_lock_next  = r_lock_idx;
    w_rr_next    = r_rr_ptr;
    if (w_xfer) begin
      if (w_gnt_last) begin
        w_state_next = ARB_IDLE;
        w_rr_next    = (w_gnt_idx == IDX_W'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
      end else begin
        w_state_next = ARB_LOCKED;
        w_lock_next  = w_gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_IDLE;
      r_rr_ptr   <= '0;
      r_lock_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_rr_ptr   <= w_rr_next;
      r_lock_idx <= w_lock_next;
    end
  end

  always_comb begin
    w_ready            = '0;
    w_ready[w_gnt_idx] = w_xfer;
  end

  assign w_in_payload = {w_gnt_last, w_gnt_idx, w_gnt_data};

  if (OUT_REG != 0) begin : g_out_reg
    tl_skid_buffer #(
      .WIDTH (PW)
    ) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (w_gnt_valid),
      .in_ready_o  (w_dn_ready),
      .in_data_i   (w_in_payload),
      .out_valid_o (w_out_valid),
      .out_ready_i (ready_i),
      .out_data_o  (w_out_payload)
    );
  end else begin : g_out_comb
    assign w_dn_ready    = ready_i;
    assign w_out_valid   = w_gnt_valid;
    assign w_out_payload = w_in_payload;
  end

  // Combinational paths are masked so every output reads zero while reset is held.
  assign ready_o                = rst_n ? w_ready : '0;
  assign valid_o                = rst_n && w_out_valid;
  assign {last_o, id_o, data_o} = rst_n ? w_out_payload : '0;
  assign locked_o               = rst_n && (r_state == ARB_LOCKED);

endmodule

// File: doc/tl_burst_arbiter.md
TL_BURST_ARBITER -- requirements
Module: tl_burst_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesting channels (N >= 2).
REQ-002 SHALL have parameter DATA_W, default 8, meaning payload width per channel.
REQ-003 SHALL have parameter OUT_REG, default 0, meaning 1 inserts a full-throughput skid-buffer output stage.
REQ-004 SHALL define IDX_W = max(1, clog2(N)) as a derived localparam.
REQ-005 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port valid_i  input  N  per-channel request valid.
REQ-008 SHALL have port ready_o  output  N  per-channel accept; at most one bit set per cycle.
REQ-009 SHALL have port data_i  input  N*DATA_W  packed payloads; channel k at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port last_i  input  N  per-channel last-beat flag, sampled with valid_i.
REQ-011 SHALL have port prio_mode_i  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-012 SHALL have port valid_o  output  1  output beat valid.
REQ-013 SHALL have port ready_i  input  1  downstream accept.
REQ-014 SHALL have port data_o  output  DATA_W  granted payload.
REQ-015 SHALL have port last_o  output  1  granted last flag.
REQ-016 SHALL have port id_o  output  IDX_W  index of the channel that sourced the output beat.
REQ-017 SHALL have port locked_o  output  1  high while a multi-beat burst holds the grant.

Function
REQ-018 SHALL implement two states: IDLE (free arbitration) and LOCKED (grant held on lock_idx).
REQ-019 In IDLE, SHALL select winner combinationally among valid_i within the same cycle (zero-latency when OUT_REG=0).
REQ-020 Round-robin SHALL search from rr_ptr upward with wrap from N-1 to 0; rr_ptr resets to 0.
REQ-021 After the last beat of a burst from channel g completes, SHALL set rr_ptr = (g+1) mod N; rr_ptr SHALL NOT change otherwise.
REQ-022 Fixed-priority mode SHALL ignore rr_ptr for selection but still update it per REQ-021.
REQ-023 A beat SHALL transfer when the winner's valid_i and ready_o are both high; ready_o[g] = internal downstream-ready for the winner only.
REQ-024 On a transfer in IDLE with last_i[g]=0, SHALL enter LOCKED with lock_idx=g.
REQ-025 In LOCKED, only lock_idx SHALL be selectable, regardless of other valid_i or prio_mode_i; valid_o SHALL follow valid_i[lock_idx].
REQ-026 In LOCKED, a transfer with last_i[lock_idx]=1 SHALL return to IDLE and update rr_ptr.
REQ-027 prio_mode_i changes SHALL take effect only at the next IDLE arbitration.
REQ-028 With no valid_i set in IDLE, valid_o SHALL be 0 and ready_o all 0.
REQ-029 When ready_i=0, selected channel's ready_o SHALL be 0 and data_o/id_o/last_o SHALL remain stable while valid_o=1 (OUT_REG=0: given stable inputs).
REQ-030 OUT_REG=1 SHALL add exactly 1 cycle latency, sustain 1 beat/cycle, and have ready_o independent of ready_i combinationally.
REQ-031 locked_o SHALL be 1 exactly in LOCKED state.

Reset
REQ-032 On rst_n low, SHALL asynchronously force: state=IDLE, rr_ptr=0, lock_idx=0, skid buffer empty.
REQ-033 During reset, valid_o=0, ready_o=0, locked_o=0, id_o=0, last_o=0, data_o=0.
REQ-034 Reset mid-burst SHALL abandon the burst; first post-reset arbitration SHALL start from channel 0.

Structure
REQ-035 SHALL place the state enum (ARB_IDLE, ARB_LOCKED) and a mode constant pair in the shared package tl_xbar_pkg.
REQ-036 SHALL implement the output stage as sub-module tl_skid_buffer (WIDTH = DATA_W+IDX_W+1), instantiated only when OUT_REG=1.

Verification (N=4, DATA_W=8, data_i channel k = 0xA0+k, ready_i=1 unless stated)
REQ-037 Single request: valid_i=0001, last_i=1111 -> data_o=0xA0, id_o=0, ready_o=0001 same cycle (OUT_REG=0).
REQ-038 Round-robin: after REQ-037, valid_i=1111 for 4 cycles, last all 1 -> data_o A1, A2, A3, A0 in order.
REQ-039 Burst lock: valid_i=1111, channel 1 sends 3 beats last=0,0,1 -> id_o=1 for 3 transfers, locked_o=1 for 2 cycles after the first beat, then next grant id_o=2.
REQ-040 Fixed priority: prio_mode_i=1, valid_i=1110 for 3 cycles -> id_o=1 each cycle; switch mode mid-burst -> lock still honored.
REQ-041 Backpressure: valid_i=0100, ready_i=0 -> valid_o=1, ready_o=0000, data_o=0xA2 held; ready_i=1 -> ready_o=0100.
REQ-042 Reset mid-burst and OUT_REG=1: rst_n low during LOCKED -> locked_o=0, valid_o=0; OUT_REG=1 rerun of REQ-038 -> same order delayed 1 cycle, no bubbles.
